// File: rtl/bit_gate_checker_pkg.sv
// Shared definitions for the 1-bit gate checker: gate bit positions,
// checker FSM encoding and the golden truth table.
package bit_gate_pkg;

  localparam int GATE_NOT  = 0;
  localparam int GATE_AND  = 1;
  localparam int GATE_OR   = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;
  localparam int GATE_CNT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Expected outputs of every gate instance for one stimulus pair.
  // NOT is driven from in1 only.
  function automatic logic [GATE_CNT-1:0] golden_gates(input logic in1, input logic in2);
    logic [GATE_CNT-1:0] g;
    g[GATE_NOT]  = ~in1;
    g[GATE_AND]  = in1 & in2;
    g[GATE_OR]   = in1 | in2;
    g[GATE_NAND] = ~(in1 & in2);
    g[GATE_NOR]  = ~(in1 | in2);
    g[GATE_XOR]  = in1 ^ in2;
    g[GATE_XNOR] = ~(in1 ^ in2);
    return g;
  endfunction

endpackage

// File: rtl/bit_gate_checker_if.sv
// Vector bus between the gate stimulus sequence and the checker:
// run control plus one applied stimulus pair and its observed gate outputs.
interface bit_gate_checker_if;
  import bit_gate_pkg::*;

  logic                start;
  logic                vec_valid;
  logic                in1;
  logic                in2;
  logic [GATE_CNT-1:0] obs;

  modport master (output start, output vec_valid, output in1, output in2, output obs);
  modport slave  (input  start, input  vec_valid, input  in1, input  in2, input  obs);

endinterface

// File: rtl/bit_gate_checker_golden.sv
// Combinational golden model: stimulus pair -> expected 7-bit gate response.
// Kept as its own block so wider checkers can reuse the same truth table.
module bit_gate_golden
  import bit_gate_pkg::*;
(
  input  logic                in1,
  input  logic                in2,
  output logic [GATE_CNT-1:0] expected
);

  assign expected = golden_gates(in1, in2);

endmodule

// File: rtl/bit_gate_checker.sv
// Response checker for the 1-bit gate set: compares observed gate outputs
// with the golden table, tracks vector/error counts, input coverage and the
// first failing vector, and reports a pass verdict at the end of each run.
module bit_gate_checker
  import bit_gate_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bit_gate_checker_if.slave    vif,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     vec_count,
  output logic [3:0]           cov,
  output logic [CNT_W-1:0]     first_fail_idx,
  output logic [GATE_CNT-1:0]  first_fail_mask
);

  state_e              state_q, state_d;
  logic                pass_q, pass_d;
  logic                mismatch_q, mismatch_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [CNT_W-1:0]    vec_q, vec_d;
  logic [3:0]          cov_q, cov_d;
  logic [CNT_W-1:0]    ff_idx_q, ff_idx_d;
  logic [GATE_CNT-1:0] ff_mask_q, ff_mask_d;

  logic [GATE_CNT-1:0] expected;
  logic [GATE_CNT-1:0] diff;
  logic                start_acc;
  logic                accept;
  logic                last_vec;

  bit_gate_golden u_golden (
    .in1      (vif.in1),
    .in2      (vif.in2),
    .expected (expected)
  );

  // Per-bit comparison using case inequality so X/Z on obs flags that bit.
  always_comb begin
    diff = '0;
    for (int i = 0; i < GATE_CNT; i++) begin
      diff[i] = (vif.obs[i] !== expected[i]);
    end
  end

  // Start is honoured only outside a run; a vector only inside one.
  assign start_acc = vif.start && (state_q != ST_RUN);
  assign accept    = vif.vec_valid && (state_q == ST_RUN);
  assign last_vec  = (vec_q == CNT_W'(NUM_VECTORS - 1));

  // Next-state, statistics and verdict computation.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    vec_d      = vec_q;
    cov_d      = cov_q;
    ff_idx_d   = ff_idx_q;
    ff_mask_d  = ff_mask_q;

    if (start_acc) begin
      state_d   = ST_RUN;
      pass_d    = 1'b0;
      err_d     = '0;
      vec_d     = '0;
      cov_d     = '0;
      ff_idx_d  = '0;
      ff_mask_d = '0;
    end else if (accept) begin
      vec_d                    = vec_q + 1'b1;
      cov_d[{vif.in1, vif.in2}] = 1'b1;
      if (diff != '0) begin
        mismatch_d = 1'b1;
        if (err_q != '1) begin
          err_d = err_q + 1'b1;
        end
        // Only the first failure of a run is recorded.
        if (err_q == '0) begin
          ff_idx_d  = vec_q;
          ff_mask_d = diff;
        end
      end
      if (last_vec) begin
        state_d = ST_DONE;
        pass_d  = (err_d == '0) && (cov_d == 4'b1111);
      end
    end
  end

  // FSM state and verdict registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  // Run statistics and first-failure capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
      err_q      <= '0;
      vec_q      <= '0;
      cov_q      <= '0;
      ff_idx_q   <= '0;
      ff_mask_q  <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      vec_q      <= vec_d;
      cov_q      <= cov_d;
      ff_idx_q   <= ff_idx_d;
      ff_mask_q  <= ff_mask_d;
    end
  end

  assign busy            = (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign mismatch        = mismatch_q;
  assign err_count       = err_q;
  assign vec_count       = vec_q;
  assign cov             = cov_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_mask = ff_mask_q;

endmodule

// File: tb/tb_bit_gate_checker.sv
// Directed bench for bit_gate_checker: a table of one-cycle vectors with
// hand-computed expected outputs, plus a hand-written mid-run reset sequence.
module tb_bit_gate_checker;

  logic       clk;
  logic       rst_n;
  logic       busy, done, pass, mismatch;
  logic [7:0] err_count, vec_count, first_fail_idx;
  logic [3:0] cov;
  logic [6:0] first_fail_mask;

  int checks = 0;
  int errors = 0;

  bit_gate_checker_if vif ();

  bit_gate_checker #(.NUM_VECTORS(4), .CNT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .vif             (vif),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .mismatch        (mismatch),
    .err_count       (err_count),
    .vec_count       (vec_count),
    .cov             (cov),
    .first_fail_idx  (first_fail_idx),
    .first_fail_mask (first_fail_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written truth table, index {in1,in2}; bits {XNOR,XOR,NOR,NAND,OR,AND,NOT}.
  logic [6:0] good [4] = '{7'b1011001, 7'b0101101, 7'b0101100, 7'b1000110};

  typedef struct {
    logic       st, vv, a, b;
    logic [6:0] flip;
    logic       busy, done, pass, mm;
    logic [7:0] err, vc;
    logic [3:0] cov;
    logic [7:0] ffi;
    logic [6:0] ffm;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(input logic st, vv, a, b, input logic [6:0] flip,
                              input logic bz, dn, ps, mm, input int err, vc,
                              input logic [3:0] cv, input int ffi, input logic [6:0] ffm);
    row_t r;
    r.st = st; r.vv = vv; r.a = a; r.b = b; r.flip = flip;
    r.busy = bz; r.done = dn; r.pass = ps; r.mm = mm;
    r.err = 8'(err); r.vc = 8'(vc); r.cov = cv; r.ffi = 8'(ffi); r.ffm = ffm;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic apply(input logic st, vv, a, b, input logic [6:0] flip);
    @(negedge clk);
    vif.start     = st;
    vif.vec_valid = vv;
    vif.in1       = a;
    vif.in2       = b;
    vif.obs       = good[{a, b}] ^ flip;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input row_t r);
    chk({tag, "_busy"}, 32'(busy),            32'(r.busy));
    chk({tag, "_done"}, 32'(done),            32'(r.done));
    chk({tag, "_pass"}, 32'(pass),            32'(r.pass));
    chk({tag, "_mm"},   32'(mismatch),        32'(r.mm));
    chk({tag, "_err"},  32'(err_count),       32'(r.err));
    chk({tag, "_vc"},   32'(vec_count),       32'(r.vc));
    chk({tag, "_cov"},  32'(cov),             32'(r.cov));
    chk({tag, "_ffi"},  32'(first_fail_idx),  32'(r.ffi));
    chk({tag, "_ffm"},  32'(first_fail_mask), 32'(r.ffm));
  endtask

  initial begin
    row_t z;
    z = mk(0,0,0,0,7'h0, 0,0,0,0, 0,0,4'h0,0,7'h0);

    rst_n = 1'b0;
    vif.start = 1'b0; vif.vec_valid = 1'b0; vif.in1 = 1'b0; vif.in2 = 1'b0; vif.obs = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", z);
    @(negedge clk);
    rst_n = 1'b1;

    //            st vv a b flip       bz dn ps mm err vc cov    ffi ffm
    // vec_valid in IDLE is ignored
    rows.push_back(mk(0,1,1,1,7'h00,   0,0,0,0, 0,0,4'b0000,0,7'h00));
    // run 1: all correct, full coverage
    rows.push_back(mk(1,0,0,0,7'h00,   1,0,0,0, 0,0,4'b0000,0,7'h00));
    rows.push_back(mk(0,1,0,0,7'h00,   1,0,0,0, 0,1,4'b0001,0,7'h00));
    rows.push_back(mk(0,1,0,1,7'h00,   1,0,0,0, 0,2,4'b0011,0,7'h00));
    rows.push_back(mk(0,1,1,0,7'h00,   1,0,0,0, 0,3,4'b0111,0,7'h00));
    rows.push_back(mk(0,1,1,1,7'h00,   0,1,1,0, 0,4,4'b1111,0,7'h00));
    rows.push_back(mk(0,0,0,0,7'h00,   0,1,1,0, 0,4,4'b1111,0,7'h00));
    // run 2: OR wrong on vector 10
    rows.push_back(mk(1,0,0,0,7'h00,   1,0,0,0, 0,0,4'b0000,0,7'h00));
    rows.push_back(mk(0,1,0,0,7'h00,   1,0,0,0, 0,1,4'b0001,0,7'h00));
    rows.push_back(mk(0,1,0,1,7'h00,   1,0,0,0, 0,2,4'b0011,0,7'h00));
    rows.push_back(mk(0,1,1,0,7'h04,   1,0,0,1, 1,3,4'b0111,2,7'h04));
    rows.push_back(mk(0,1,1,1,7'h00,   0,1,0,0, 1,4,4'b1111,2,7'h04));
    // run 3: AND wrong at idx 1, XNOR wrong at idx 3
    rows.push_back(mk(1,0,0,0,7'h00,   1,0,0,0, 0,0,4'b0000,0,7'h00));
    rows.push_back(mk(0,1,0,0,7'h00,   1,0,0,0, 0,1,4'b0001,0,7'h00));
    rows.push_back(mk(0,1,0,1,7'h02,   1,0,0,1, 1,2,4'b0011,1,7'h02));
    rows.push_back(mk(0,1,1,0,7'h00,   1,0,0,0, 1,3,4'b0111,1,7'h02));
    rows.push_back(mk(0,1,1,1,7'h40,   0,1,0,1, 2,4,4'b1111,1,7'h02));
    rows.push_back(mk(0,0,0,0,7'h00,   0,1,0,0, 2,4,4'b1111,1,7'h02));
    // run 4: correct gates, incomplete coverage
    rows.push_back(mk(1,0,0,0,7'h00,   1,0,0,0, 0,0,4'b0000,0,7'h00));
    rows.push_back(mk(0,1,0,0,7'h00,   1,0,0,0, 0,1,4'b0001,0,7'h00));
    rows.push_back(mk(0,1,0,1,7'h00,   1,0,0,0, 0,2,4'b0011,0,7'h00));
    rows.push_back(mk(0,1,0,1,7'h00,   1,0,0,0, 0,3,4'b0011,0,7'h00));
    rows.push_back(mk(0,1,0,0,7'h00,   0,1,0,0, 0,4,4'b0011,0,7'h00));
    // vec_valid in DONE ignored; start+valid: vector dropped; start mid-run ignored
    rows.push_back(mk(0,1,1,1,7'h7f,   0,1,0,0, 0,4,4'b0011,0,7'h00));
    rows.push_back(mk(1,1,1,1,7'h7f,   1,0,0,0, 0,0,4'b0000,0,7'h00));
    rows.push_back(mk(0,1,0,0,7'h00,   1,0,0,0, 0,1,4'b0001,0,7'h00));
    rows.push_back(mk(1,0,0,0,7'h00,   1,0,0,0, 0,1,4'b0001,0,7'h00));
    rows.push_back(mk(0,1,0,1,7'h00,   1,0,0,0, 0,2,4'b0011,0,7'h00));
    rows.push_back(mk(0,1,1,0,7'h00,   1,0,0,0, 0,3,4'b0111,0,7'h00));
    rows.push_back(mk(0,1,1,1,7'h00,   0,1,1,0, 0,4,4'b1111,0,7'h00));

    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i].st, rows[i].vv, rows[i].a, rows[i].b, rows[i].flip);
      check_all($sformatf("row%0d", i), rows[i]);
    end

    // Mid-run reset: start, two vectors (one failing), then async reset between edges.
    apply(1, 0, 0, 0, 7'h00);
    apply(0, 1, 0, 0, 7'h01);
    apply(0, 1, 0, 1, 7'h00);
    chk("pre_rst_vc",  32'(vec_count), 32'd2);
    chk("pre_rst_err", 32'(err_count), 32'd1);
    @(negedge clk);
    vif.start = 1'b0; vif.vec_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", z);
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 1, 1, 1, 7'h00);
    check_all("post_rst_idle", z);

    // Clean run after reset.
    apply(1, 0, 0, 0, 7'h00);
    apply(0, 1, 0, 0, 7'h00);
    apply(0, 1, 0, 1, 7'h00);
    apply(0, 1, 1, 0, 7'h00);
    apply(0, 1, 1, 1, 7'h00);
    check_all("post_rst_run", mk(0,0,0,0,7'h00, 0,1,1,0, 0,4,4'b1111,0,7'h00));

    @(negedge clk);
    vif.start = 1'b0; vif.vec_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
